// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled majority-vote sampling, 2-entry RCREG FIFO
// and RCSTA control/status (SPEN, CREN, FERR, OERR).
module uart_rx #(
   parameter int FIFO_DEPTH  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UART_RXD,
   input  logic [7:0] reg_data_in,
   input  logic       rcsta_reg_wr_en,
   output logic [7:0] rcsta_reg_out,
   input  logic [7:0] spbrg,
   input  logic       brgh,
   input  logic       rcreg_rd_en,
   output logic [7:0] rcreg_out,
   output logic       rxif_set_en
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   spen_q, spen_d;
   logic                   cren_q, cren_d;
   logic                   oerr_q, oerr_d;
   state_e                 state_q, state_d;
   logic [9:0]             presc_q, presc_d;
   logic [3:0]             tick_q, tick_d;
   logic [2:0]             idx_q, idx_d;
   logic [1:0]             samp_q, samp_d;
   logic [7:0]             shift_q, shift_d;
   logic [8:0]             mem_q [FIFO_DEPTH];
   logic [8:0]             mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic             rxd_s;
   logic [9:0]       presc_term_s;
   logic             tick_s;
   logic             maj_s;
   logic             active_s;
   logic             abort_s;
   logic             flush_s;
   logic             kill_s;
   logic             push_req_s;
   logic             push_ferr_s;
   logic             pop_s;
   logic             ovf_s;
   logic [PTR_W-1:0] rd_after_s;
   logic [CNT_W-1:0] cnt_after_s;
   logic [PTR_W-1:0] wr_idx_s;
   logic [8:0]       head_s;
   logic             unused_s;

   assign rxd_s        = sync_q[SYNC_STAGES-1];
   // BRGH=0 divides by 4*(SPBRG+1): terminal count is {spbrg, 2'b11}
   assign presc_term_s = brgh ? {2'b00, spbrg} : {spbrg, 2'b11};
   assign tick_s       = (presc_q == presc_term_s);
   assign maj_s        = majority3(samp_q[0], samp_q[1], rxd_s);
   assign active_s     = spen_q & cren_q & ~oerr_q;
   assign abort_s      = rcsta_reg_wr_en & (~reg_data_in[7] | ~reg_data_in[4]);
   assign flush_s      = rcsta_reg_wr_en & ~reg_data_in[7];
   assign kill_s       = ~active_s | abort_s;
   assign unused_s     = ^{reg_data_in[6:5], reg_data_in[3:0]};

   // RCSTA control bits; leaving reception clears an overrun.
   always_comb begin
      spen_d = spen_q;
      cren_d = cren_q;
      if (rcsta_reg_wr_en) begin
         spen_d = reg_data_in[7];
         cren_d = reg_data_in[4];
         if (!reg_data_in[7] || !reg_data_in[4]) begin
            oerr_d = 1'b0;
         end else begin
            oerr_d = oerr_q | ovf_s;
         end
      end else begin
         oerr_d = oerr_q | ovf_s;
      end
   end

   // Receive FSM with prescaler, tick counter and majority sampling.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      tick_d      = tick_q;
      idx_d       = idx_q;
      samp_d      = samp_q;
      shift_d     = shift_q;
      push_req_s  = 1'b0;
      push_ferr_s = 1'b0;
      if (kill_s) begin
         state_d = ST_IDLE;
         presc_d = 10'd0;
         tick_d  = 4'd0;
         idx_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d = 10'd0;
               tick_d  = 4'd0;
               idx_d   = 3'd0;
               if (!rxd_s) begin
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_START, ST_DATA, ST_STOP: begin
               if (tick_s) begin
                  presc_d = 10'd0;
                  tick_d  = tick_q + 4'd1;
                  if (tick_q == 4'd7) begin
                     samp_d[0] = rxd_s;
                  end else if (tick_q == 4'd8) begin
                     samp_d[1] = rxd_s;
                  end else if (tick_q == 4'd9) begin
                     case (state_q)
                        ST_START: begin
                           if (maj_s) begin
                              state_d = ST_IDLE;
                              tick_d  = 4'd0;
                           end else begin
                              state_d = ST_START;
                           end
                        end
                        ST_DATA:  shift_d = {maj_s, shift_q[7:1]};
                        ST_STOP: begin
                           // Return to IDLE right away so a back-to-back start edge is seen
                           push_req_s  = 1'b1;
                           push_ferr_s = ~maj_s;
                           state_d     = ST_IDLE;
                           tick_d      = 4'd0;
                        end
                        default:  state_d = ST_IDLE;
                     endcase
                  end else if (tick_q == 4'd15) begin
                     case (state_q)
                        ST_START: begin
                           state_d = ST_DATA;
                           idx_d   = 3'd0;
                        end
                        ST_DATA: begin
                           if (idx_q == 3'd7) begin
                              state_d = ST_STOP;
                              idx_d   = 3'd0;
                           end else begin
                              idx_d = idx_q + 3'd1;
                           end
                        end
                        default:  state_d = ST_IDLE;
                     endcase
                  end else begin
                     samp_d = samp_q;
                  end
               end else begin
                  presc_d = presc_q + 10'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pop_s       = rcreg_rd_en & (cnt_q != {CNT_W{1'b0}});
   assign rd_after_s  = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   assign cnt_after_s = cnt_q - CNT_W'(pop_s);
   assign wr_idx_s    = rd_after_s + PTR_W'(cnt_after_s);

   // FIFO update: a same-cycle pop frees space before the push is considered.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_after_s;
      cnt_d    = cnt_after_s;
      ovf_s    = 1'b0;
      if (flush_s) begin
         rd_ptr_d = {PTR_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
      end else if (push_req_s) begin
         if (cnt_after_s == CNT_W'(FIFO_DEPTH)) begin
            ovf_s = 1'b1;
         end else begin
            mem_d[wr_idx_s] = {push_ferr_s, shift_q};
            cnt_d           = cnt_after_s + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_after_s;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q   <= {SYNC_STAGES{1'b1}};
         spen_q   <= 1'b0;
         cren_q   <= 1'b0;
         oerr_q   <= 1'b0;
         state_q  <= ST_IDLE;
         presc_q  <= 10'd0;
         tick_q   <= 4'd0;
         idx_q    <= 3'd0;
         samp_q   <= 2'b00;
         shift_q  <= 8'h00;
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 9'h000;
         end
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
         spen_q   <= spen_d;
         cren_q   <= cren_d;
         oerr_q   <= oerr_d;
         state_q  <= state_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         idx_q    <= idx_d;
         samp_q   <= samp_d;
         shift_q  <= shift_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign head_s        = mem_q[rd_ptr_q];
   assign rxif_set_en   = (cnt_q != {CNT_W{1'b0}});
   assign rcreg_out     = rxif_set_en ? head_s[7:0] : 8'h00;
   assign rcsta_reg_out = {spen_q, 1'b0, 1'b0, cren_q, 1'b0,
                           rxif_set_en & head_s[8], oerr_q, 1'b0};

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a frame-level model (byte queue plus RCSTA bits)
// predicts every output each cycle outside the stop-bit window where the push lands.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       UART_RXD;
   logic [7:0] reg_data_in;
   logic       rcsta_reg_wr_en;
   logic [7:0] rcsta_reg_out;
   logic [7:0] spbrg;
   logic       brgh;
   logic       rcreg_rd_en;
   logic [7:0] rcreg_out;
   logic       rxif_set_en;

   int checks = 0;
   int errors = 0;

   bit [8:0] mq[$];
   bit       m_spen, m_cren, m_oerr;
   bit       chk_en = 1'b0;
   bit       rd_pending = 1'b0, wr_pending = 1'b0, rst_pending = 1'b0;

   uart_rx #(.FIFO_DEPTH(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .UART_RXD(UART_RXD), .reg_data_in(reg_data_in),
      .rcsta_reg_wr_en(rcsta_reg_wr_en), .rcsta_reg_out(rcsta_reg_out),
      .spbrg(spbrg), .brgh(brgh), .rcreg_rd_en(rcreg_rd_en),
      .rcreg_out(rcreg_out), .rxif_set_en(rxif_set_en)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d expected range [%0d,%0d] at %0t", nm, act, lo, hi, $time);
      end
   endfunction

   function automatic void model_reset();
      m_spen = 1'b0;
      m_cren = 1'b0;
      m_oerr = 1'b0;
      mq.delete();
   endfunction

   function automatic void model_write(input logic [7:0] v);
      m_spen = v[7];
      m_cren = v[4];
      if (!v[7] || !v[4]) m_oerr = 1'b0;
      if (!v[7]) mq.delete();
   endfunction

   function automatic bit model_active();
      return m_spen && m_cren && !m_oerr;
   endfunction

   function automatic logic [7:0] exp_rcsta();
      logic f;
      f = (mq.size() > 0) ? mq[0][8] : 1'b0;
      return {m_spen, 1'b0, 1'b0, m_cren, 1'b0, f, m_oerr, 1'b0};
   endfunction

   function automatic logic [7:0] exp_rcreg();
      logic [8:0] h;
      h = (mq.size() > 0) ? mq[0] : 9'h000;
      return h[7:0];
   endfunction

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rxif", rxif_set_en, (mq.size() > 0));
         chk("rcreg", rcreg_out, exp_rcreg());
         chk("rcsta", rcsta_reg_out, exp_rcsta());
      end
   end

   // One clock: the model absorbs whatever strobes were presented during it
   task automatic step();
      @(posedge clk);
      #1;
      if (rd_pending) begin
         if (mq.size() > 0) void'(mq.pop_front());
         rcreg_rd_en = 1'b0;
         rd_pending  = 1'b0;
      end
      if (wr_pending) begin
         model_write(reg_data_in);
         rcsta_reg_wr_en = 1'b0;
         wr_pending      = 1'b0;
      end
      if (rst_pending) begin
         model_reset();
         rst         = 1'b1;
         rst_pending = 1'b0;
      end
   endtask

   task automatic rd();
      rcreg_rd_en = 1'b1;
      rd_pending  = 1'b1;
      step();
   endtask

   task automatic wr(input logic [7:0] v);
      reg_data_in     = v;
      rcsta_reg_wr_en = 1'b1;
      wr_pending      = 1'b1;
      step();
   endtask

   task automatic idle(input int n);
      UART_RXD = 1'b1;
      repeat (n) step();
   endtask

   // Drive one frame; act_kind 1 writes RCSTA, 2 pulses reset, mid-way through bit act_bit
   task automatic send_frame(input logic [7:0] b, input bit stop_v, input int bitclks,
                             input int act_bit, input int act_kind, input logic [7:0] act_val);
      bit val, seen, pre_active;
      int rise, pre_occ;
      seen = 1'b0;
      rise = -1;
      pre_occ = 0;
      pre_active = 1'b0;
      for (int bi = 0; bi < 10; bi++) begin
         val = (bi == 0) ? 1'b0 : (bi == 9) ? stop_v : b[bi-1];
         if (bi == 9) begin
            chk_en     = 1'b0;
            pre_occ    = mq.size();
            pre_active = model_active();
         end
         for (int c = 0; c < bitclks; c++) begin
            UART_RXD = val;
            if (bi == act_bit && c == bitclks / 2) begin
               if (act_kind == 1) begin
                  reg_data_in     = act_val;
                  rcsta_reg_wr_en = 1'b1;
                  wr_pending      = 1'b1;
               end else if (act_kind == 2) begin
                  rst         = 1'b0;
                  rst_pending = 1'b1;
               end
            end
            if (bi == 9) begin
               @(negedge clk);
               if (!seen && rxif_set_en) begin
                  seen = 1'b1;
                  rise = c;
               end
            end
            step();
         end
      end
      UART_RXD = 1'b1;
      if (pre_occ == 0) begin
         if (pre_active) chk_rng("rxif_rise", rise, bitclks / 3, (2 * bitclks) / 3 + 6);
         else            chk("rxif_no_push", seen, 1'b0);
      end
      if (pre_active) begin
         if (mq.size() == 2) m_oerr = 1'b1;
         else                mq.push_back({~stop_v, b});
      end
      chk_en = 1'b1;
   endtask

   initial begin
      int cfg, gap, nrd, bitclks;
      logic [7:0] rb;
      bit ferr;
      rst = 1'b0;
      UART_RXD = 1'b1;
      reg_data_in = 8'h00;
      rcsta_reg_wr_en = 1'b0;
      rcreg_rd_en = 1'b0;
      brgh = 1'b1;
      spbrg = 8'h00;
      model_reset();
      repeat (3) step();
      chk("reset_rcsta", rcsta_reg_out, 8'h00);
      chk("reset_rcreg", rcreg_out, 8'h00);
      chk("reset_rxif", rxif_set_en, 1'b0);
      rst = 1'b1;
      chk_en = 1'b1;
      idle(4);

      // Basic receive
      wr(8'h90);
      send_frame(8'h35, 1'b1, 16, -1, 0, 8'h00);
      idle(2);
      chk("basic_data", rcreg_out, 8'h35);
      chk("basic_rcsta", rcsta_reg_out, 8'h90);
      chk("basic_rxif", rxif_set_en, 1'b1);
      rd();
      chk("basic_pop_data", rcreg_out, 8'h00);
      chk("basic_pop_rxif", rxif_set_en, 1'b0);

      // Framing error
      send_frame(8'hA5, 1'b0, 16, -1, 0, 8'h00);
      idle(32);
      chk("ferr_data", rcreg_out, 8'hA5);
      chk("ferr_rcsta", rcsta_reg_out, 8'h94);
      rd();
      chk("ferr_pop_rcsta", rcsta_reg_out, 8'h90);

      // Overrun
      send_frame(8'h11, 1'b1, 16, -1, 0, 8'h00);
      send_frame(8'h22, 1'b1, 16, -1, 0, 8'h00);
      send_frame(8'h33, 1'b1, 16, -1, 0, 8'h00);
      send_frame(8'h44, 1'b1, 16, -1, 0, 8'h00);
      idle(4);
      chk("ovr_rcsta", rcsta_reg_out, 8'h92);
      chk("ovr_head", rcreg_out, 8'h11);
      wr(8'h80);
      chk("ovr_clear", rcsta_reg_out, 8'h80);
      wr(8'h90);
      chk("ovr_first", rcreg_out, 8'h11);
      rd();
      chk("ovr_second", rcreg_out, 8'h22);
      rd();
      chk("ovr_empty", rxif_set_en, 1'b0);

      // Glitch rejection
      UART_RXD = 1'b0;
      repeat (3) step();
      idle(40);
      chk("glitch_rxif", rxif_set_en, 1'b0);
      send_frame(8'h5A, 1'b1, 16, -1, 0, 8'h00);
      idle(2);
      chk("glitch_next", rcreg_out, 8'h5A);
      rd();

      // Slow baud: 4*(1+1) clks per tick, 128 clks per bit
      brgh = 1'b0;
      spbrg = 8'h01;
      idle(2);
      send_frame(8'hC3, 1'b1, 128, -1, 0, 8'h00);
      idle(2);
      chk("slow_data", rcreg_out, 8'hC3);
      chk("slow_rcsta", rcsta_reg_out, 8'h90);
      rd();
      brgh = 1'b1;
      spbrg = 8'h00;
      idle(2);

      // CREN cleared during data bit 4, then a full frame after re-enabling
      send_frame(8'h00, 1'b1, 16, 5, 1, 8'h80);
      idle(20);
      chk("cren_abort_rxif", rxif_set_en, 1'b0);
      wr(8'h90);
      send_frame(8'h96, 1'b1, 16, -1, 0, 8'h00);
      idle(2);
      chk("cren_next", rcreg_out, 8'h96);

      // Reset during data bit 4 of 0xFF, with a byte still queued
      send_frame(8'hFF, 1'b1, 16, 5, 2, 8'h00);
      idle(2);
      chk("rst_rcsta", rcsta_reg_out, 8'h00);
      chk("rst_rcreg", rcreg_out, 8'h00);
      chk("rst_rxif", rxif_set_en, 1'b0);
      wr(8'h90);

      // Randomised frames, baud rates, reads and overrun recovery
      for (int it = 0; it < 30; it++) begin
         cfg = $urandom_range(0, 2);
         case (cfg)
            0: begin brgh = 1'b1; spbrg = 8'h00; bitclks = 16; end
            1: begin brgh = 1'b1; spbrg = 8'h02; bitclks = 48; end
            default: begin brgh = 1'b0; spbrg = 8'h00; bitclks = 64; end
         endcase
         rb = 8'($urandom);
         ferr = ($urandom_range(0, 7) == 0);
         send_frame(rb, ~ferr, bitclks, -1, 0, 8'h00);
         gap = ferr ? 1 + $urandom_range(0, 2) : $urandom_range(0, 2);
         idle(gap * bitclks);
         nrd = $urandom_range(0, 2);
         for (int k = 0; k < nrd; k++) rd();
         if (m_oerr && $urandom_range(0, 1) == 1) begin
            wr(8'h80);
            wr(8'h90);
         end
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver for the PIC16F-compatible UART peripheral; the receive-side counterpart of the existing transmit shift register path.
- Receives 8N1 frames on UART_RXD using 16x oversampling with majority-vote bit sampling.
- Buffers received bytes in a 2-deep RCREG FIFO and exposes RCSTA status/control bits.
- Takes baud configuration (SPBRG value and BRGH bit) from the shared TXSTA/SPBRG registers and drives the receive interrupt flag strobe.

Parameters:
- FIFO_DEPTH, 2, RCREG FIFO entries (fixed at 2 for PIC compatibility; other values unsupported).
- SYNC_STAGES, 2, number of input synchronizer flops on UART_RXD.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- UART_RXD  in  1  serial input, idle high, asynchronous to clk
- reg_data_in  in  8  general data-in bus
- rcsta_reg_wr_en  in  1  write strobe for RCSTA
- rcsta_reg_out  out  8  RCSTA readback: {SPEN,1'b0,1'b0,CREN,1'b0,FERR,OERR,1'b0}
- spbrg  in  8  baud divisor from SPBRG register
- brgh  in  1  high-baud select from TXSTA
- rcreg_rd_en  in  1  read strobe for RCREG; pops FIFO head
- rcreg_out  out  8  FIFO head data; 8'h00 when empty
- rxif_set_en  out  1  high while FIFO non-empty (level used as strobe)

Behaviour:
- Reset (rst==0 at clock edge): SPEN=0, CREN=0, OERR=0, FIFO empty, FSM IDLE, synchronizer flops =1, counters 0. Outputs: rcsta_reg_out=8'h00, rcreg_out=8'h00, rxif_set_en=0. Reset mid-frame discards the partial byte.
- RCSTA write: SPEN<=reg_data_in[7], CREN<=reg_data_in[4]; all other bits are read-only.
  - Writing CREN=0: aborts any in-flight frame (FSM to IDLE), clears OERR, retains FIFO.
  - Writing SPEN=0: aborts frame, clears OERR, flushes FIFO.
- Sample tick: prescaler generates one tick every (spbrg+1) clks when brgh=1, every 4*(spbrg+1) clks when brgh=0. One bit = 16 ticks.
  - Prescaler and tick counter (0..15) reset to 0 on START entry, so sampling is aligned to the detected edge.
- rxd_s: UART_RXD after SYNC_STAGES flops. Input-to-rxd_s latency is 2 clks.
- FSM states IDLE, START, DATA, STOP. Receiver is active only when SPEN=1, CREN=1, OERR=0; otherwise FSM is held in IDLE.
  - IDLE: rxd_s==0 while active -> START.
  - START, DATA, STOP: sample rxd_s on ticks 7, 8 and 9; bit value = majority of the 3 samples, decided at tick 9.
  - START: majority 1 -> IDLE (false start / glitch). Majority 0 -> continue to tick 15, then DATA with bit index 0.
  - DATA: at tick 9, shift the majority bit into the shift register LSB-first. At tick 15, increment the index; after index 7 -> STOP.
  - STOP: at tick 9, push {byte, ferr=~majority} into the FIFO and go to IDLE in the same cycle, so a start edge immediately following can be caught.
- FIFO: 2 entries; each entry stores data[7:0] and a ferr bit.
  - rcreg_out = head data; FERR in rcsta_reg_out = head ferr (0 when empty).
  - rcreg_rd_en with FIFO empty: no effect.
  - Push while full: byte discarded, OERR<=1, FIFO contents unchanged.
  - Push and pop in the same cycle: pop happens first, push succeeds, no OERR, occupancy unchanged.
- rxif_set_en = FIFO non-empty, combinational from occupancy. Asserted the clk after the STOP push cycle.
- Widths: prescaler 10 bits (max 4*256); tick counter 4 bits; bit index 3 bits. Every counter wraps to 0 at its terminal count.
- Frame timing, brgh=1, spbrg=0: falling edge on UART_RXD at clk N -> push at clk N+2+16*9+9 = N+155 -> rxif_set_en high at N+156.

Test Plan:
- Basic receive: rst released, RCSTA<=8'h90, brgh=1, spbrg=0, drive 8'h35 at 16 clks/bit -> rxif_set_en=1, rcreg_out=8'h35, rcsta_reg_out=8'h90; one rcreg_rd_en -> rxif_set_en=0, rcreg_out=8'h00.
- Framing error: send 8'hA5 with stop bit driven 0 for one bit time -> rcreg_out=8'hA5, rcsta_reg_out[2]=1; after pop rcsta_reg_out[2]=0.
- Overrun: send 8'h11, 8'h22, 8'h33 with no reads -> FIFO holds 11 then 22, OERR=1; a fourth byte 8'h44 is ignored. Write RCSTA=8'h80 -> OERR=0. Write RCSTA=8'h90, pop twice -> 8'h11 then 8'h22.
- Glitch rejection: 3-clk low pulse on UART_RXD (brgh=1, spbrg=0) -> FSM returns to IDLE, rxif_set_en stays 0. A full 8'h5A frame sent next is received correctly.
- Slow baud: brgh=0, spbrg=1 (128 clks/bit), send 8'hC3 -> rcreg_out=8'hC3, FERR=0. Push at 128*9+8*(9+1)... verify rxif_set_en rises within the stop bit's middle third.
- Reset/abort mid-frame: assert rst=0 during data bit 4 of 8'hFF -> all outputs reset, nothing received. Separately, clear CREN mid-frame -> no push; the next complete frame, sent after setting CREN=1, is received correctly.
